// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------------------
// Module   : i2c_pkg
// Brief    : Shared types and status codes for the I2C transaction sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      ISSUE     = 3'd2,
      WAIT_BUSY = 3'd3,
      RUN       = 3'd4,
      RESP      = 3'd5
   } seq_state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_NACK    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_BADLEN  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/i2c_byte_buf.sv
//------------------------------------------------------------------------------
// Module   : i2c_byte_buf
// Brief    : Payload register file with bounded write pointer and saturating read pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_byte_buf #(
   parameter int MAX_BYTES = 4
) (
   input  logic                           clk_400,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic [$clog2(MAX_BYTES):0]     len,
   input  logic                           wr_en,
   input  logic [7:0]                     wr_data,
   input  logic                           adv,
   output logic [7:0]                     rd_data,
   output logic [$clog2(MAX_BYTES):0]     wr_ptr
);

   localparam int c_idx_w = $clog2(MAX_BYTES);
   localparam int c_ptr_w = c_idx_w + 1;

   logic [7:0]         r_mem [MAX_BYTES];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;

   always_ff @(posedge clk_400) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_BYTES; i++) r_mem[i] <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (wr_en && (r_wr_ptr < len)) begin
            r_mem[r_wr_ptr[c_idx_w-1:0]] <= wr_data;
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         // Stop on the last valid byte so surplus advances never expose stale data
         if (adv && ((r_rd_ptr + c_ptr_w'(1)) < len))
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
   end

   assign rd_data = r_mem[r_rd_ptr[c_idx_w-1:0]];
   assign wr_ptr  = r_wr_ptr;

endmodule

`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module   : i2c_txn_sequencer
// Brief    : Command front end for the I2C byte master: buffering, sequencing, status, watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_txn_sequencer
   import i2c_pkg::*;
#(
   parameter int MAX_BYTES   = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                        clk_400,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_rw,
   input  logic [6:0]                  cmd_dev_addr,
   input  logic [$clog2(MAX_BYTES):0]  cmd_len,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [7:0]                  wr_data,
   output logic                        rd_valid,
   output logic [7:0]                  rd_data,
   output logic                        rsp_valid,
   output logic [1:0]                  rsp_status,
   output logic                        m_start,
   output logic                        m_rw,
   output logic [6:0]                  m_addr,
   output logic [7:0]                  m_wdata,
   output logic                        m_more,
   input  logic                        m_wbyte_taken,
   input  logic [7:0]                  m_rdata,
   input  logic                        m_rdata_valid,
   input  logic                        m_busy,
   input  logic                        m_done,
   input  logic                        m_ack_error
);

   localparam int                c_len_w    = $clog2(MAX_BYTES) + 1;
   localparam int                c_tmo_w    = $clog2(TIMEOUT_CYC);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

   seq_state_t         r_state;
   logic [c_len_w-1:0] r_len;
   logic [c_len_w-1:0] r_remaining;
   logic [c_tmo_w-1:0] r_timer;
   logic               r_nack;
   logic               r_resp_pend;

   logic               w_accept;
   logic               w_len_bad;
   logic               w_timeout;
   logic               w_byte_in;
   logic               w_buf_wr;
   logic               w_buf_adv;
   logic [c_len_w-1:0] w_wr_ptr;

   assign w_accept  = (r_state == IDLE) && cmd_valid && cmd_ready;
   assign w_len_bad = (cmd_len == '0) || (cmd_len > c_len_w'(MAX_BYTES));
   assign w_timeout = (r_timer == c_tmo_last);
   assign w_byte_in = (r_state == RUN) && m_rw && m_rdata_valid;
   assign w_buf_wr  = (r_state == LOAD) && wr_valid && wr_ready;
   assign w_buf_adv = (r_state == RUN) && !m_rw && m_wbyte_taken;
   assign m_more    = ((r_state == ISSUE) || (r_state == WAIT_BUSY) || (r_state == RUN))
                      && (r_remaining > c_len_w'(1));

   i2c_byte_buf #(
      .MAX_BYTES (MAX_BYTES)
   ) u_buf (
      .clk_400 (clk_400),
      .rst_n   (rst_n),
      .clr     (w_accept),
      .len     (r_len),
      .wr_en   (w_buf_wr),
      .wr_data (wr_data),
      .adv     (w_buf_adv),
      .rd_data (m_wdata),
      .wr_ptr  (w_wr_ptr)
   );

   always_ff @(posedge clk_400) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_remaining <= '0;
         r_timer     <= '0;
         r_nack      <= 1'b0;
         r_resp_pend <= 1'b0;
         cmd_ready   <= 1'b0;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= 8'h00;
         rsp_valid   <= 1'b0;
         rsp_status  <= ST_OK;
         m_start     <= 1'b0;
         m_rw        <= 1'b0;
         m_addr      <= 7'h00;
      end else begin
         m_start   <= 1'b0;
         rd_valid  <= 1'b0;
         rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (w_accept) begin
                  cmd_ready   <= 1'b0;
                  r_len       <= cmd_len;
                  r_nack      <= 1'b0;
                  r_resp_pend <= 1'b0;
                  if (w_len_bad) begin
                     r_state    <= RESP;
                     rsp_valid  <= 1'b1;
                     rsp_status <= ST_BADLEN;
                  end else begin
                     m_rw        <= cmd_rw;
                     m_addr      <= cmd_dev_addr;
                     r_remaining <= cmd_len;
                     if (cmd_rw) begin
                        r_state <= ISSUE;
                        m_start <= 1'b1;
                        r_timer <= '0;
                     end else begin
                        r_state  <= LOAD;
                        wr_ready <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               if (w_buf_wr && ((w_wr_ptr + c_len_w'(1)) == r_len)) begin
                  wr_ready <= 1'b0;
                  r_state  <= ISSUE;
                  m_start  <= 1'b1;
                  r_timer  <= '0;
               end
            end
            ISSUE: begin
               r_state <= WAIT_BUSY;
               r_timer <= r_timer + c_tmo_w'(1);
            end
            WAIT_BUSY, RUN: begin
               if ((r_state == RUN) && m_ack_error) r_nack <= 1'b1;
               if (w_byte_in) begin
                  rd_valid <= 1'b1;
                  rd_data  <= m_rdata;
                  if (r_remaining != '0) r_remaining <= r_remaining - c_len_w'(1);
               end
               if (w_buf_adv && (r_remaining > c_len_w'(1)))
                  r_remaining <= r_remaining - c_len_w'(1);
               // A byte landing on the final cycle delays the response by one cycle
               if (w_timeout) begin
                  r_state     <= RESP;
                  rsp_status  <= ST_TIMEOUT;
                  rsp_valid   <= !w_byte_in;
                  r_resp_pend <= w_byte_in;
               end else if (r_state == WAIT_BUSY) begin
                  r_timer <= r_timer + c_tmo_w'(1);
                  if (m_busy) r_state <= RUN;
               end else begin
                  r_timer <= r_timer + c_tmo_w'(1);
                  if (m_done) begin
                     r_state     <= RESP;
                     rsp_status  <= (r_nack || m_ack_error) ? ST_NACK : ST_OK;
                     rsp_valid   <= !w_byte_in;
                     r_resp_pend <= w_byte_in;
                  end
               end
            end
            RESP: begin
               if (r_resp_pend) begin
                  r_resp_pend <= 1'b0;
                  rsp_valid   <= 1'b1;
               end else begin
                  r_state   <= IDLE;
                  cmd_ready <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_i2c_txn_sequencer
// Brief    : Directed bench with transaction-level expectation queues for i2c_txn_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_txn_sequencer;
   import i2c_pkg::*;

   logic       clk_400 = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
   logic [6:0] cmd_dev_addr = 7'h00;
   logic [2:0] cmd_len = 3'd0;
   logic       wr_valid = 1'b0, wr_ready;
   logic [7:0] wr_data = 8'h00;
   logic       rd_valid, rsp_valid, m_start, m_rw, m_more;
   logic [7:0] rd_data, m_wdata;
   logic [1:0] rsp_status;
   logic [6:0] m_addr;
   logic       m_wbyte_taken = 1'b0, m_rdata_valid = 1'b0;
   logic       m_busy = 1'b0, m_done = 1'b0, m_ack_error = 1'b0;
   logic [7:0] m_rdata = 8'h00;

   i2c_txn_sequencer #(.MAX_BYTES(4), .TIMEOUT_CYC(16)) dut (
      .clk_400(clk_400), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev_addr(cmd_dev_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_more(m_more),
      .m_wbyte_taken(m_wbyte_taken), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
      .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error)
   );

   always #5 clk_400 = ~clk_400;

   int cyc = 0;
   always @(posedge clk_400) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected-behaviour model: what each command must produce, held as queues
   typedef struct { int at; logic [7:0] data; } rd_exp_t;
   rd_exp_t    exp_rd[$];
   logic [1:0] exp_rsp[$];
   logic [7:0] exp_w[$];
   int         rd_left = 0;
   int         n_start = 0;
   logic       prev_start = 1'b0;

   always @(negedge clk_400) begin
      if (rst_n) begin
         if (m_start) begin
            chk("start_width", prev_start, 1'b0);
            n_start++;
         end
         prev_start = m_start;
         if (m_wbyte_taken && exp_w.size() > 0) begin
            chk("m_wdata", m_wdata, exp_w[0]);
            chk("m_more_wr", m_more, exp_w.size() > 1);
            void'(exp_w.pop_front());
         end
         if (m_rdata_valid && rd_left > 0) begin
            chk("m_more_rd", m_more, rd_left > 1);
            rd_left--;
         end
         while (exp_rd.size() > 0 && exp_rd[0].at < cyc) begin
            chk("rd_valid_missed", cyc, exp_rd[0].at);
            void'(exp_rd.pop_front());
         end
         if (rd_valid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
            else begin
               chk("rd_cycle", cyc, exp_rd[0].at);
               chk("rd_data", rd_data, exp_rd[0].data);
               void'(exp_rd.pop_front());
            end
         end
         if (rsp_valid) begin
            chk("rsp_with_rd", rd_valid, 1'b0);
            if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
            else begin
               chk("rsp_status", rsp_status, exp_rsp[0]);
               void'(exp_rsp.pop_front());
            end
         end
      end else prev_start = 1'b0;
   end

   task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [2:0] len, output int acc);
      @(posedge clk_400); #1;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = a; cmd_len = len;
      acc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_400);
         if (cmd_ready) begin acc = cyc; break; end
      end
      chk("cmd_accepted", acc >= 0, 1'b1);
      @(posedge clk_400); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic load(input logic [31:0] bytes, input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1; wr_data = bytes[8*i +: 8];
         ok = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk_400);
            if (wr_ready) begin ok = 1'b1; break; end
         end
         if (!ok) chk("wr_ready_seen", ok, 1'b1);
         @(posedge clk_400); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_start(output int at);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_400);
         if (m_start) begin at = cyc; break; end
      end
      chk("start_seen", at >= 0, 1'b1);
   endtask

   task automatic wait_rsp(output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_400);
         if (rsp_valid) begin at = cyc; break; end
      end
      chk("rsp_seen", at >= 0, 1'b1);
   endtask

   task automatic master_write(input int n, input bit nack, input bit extra, input logic [7:0] last);
      @(posedge clk_400); #1; m_busy = 1'b1;
      @(posedge clk_400); #1;
      if (nack) begin
         m_ack_error = 1'b1;
         @(posedge clk_400); #1; m_ack_error = 1'b0;
      end else begin
         for (int i = 0; i < n; i++) begin
            m_wbyte_taken = 1'b1;
            @(posedge clk_400); #1; m_wbyte_taken = 1'b0;
            @(posedge clk_400); #1;
         end
         if (extra) begin
            m_wbyte_taken = 1'b1;
            @(posedge clk_400); #1; m_wbyte_taken = 1'b0;
            @(negedge clk_400);
            chk("wdata_saturated", m_wdata, last);
            @(posedge clk_400); #1;
         end
      end
      m_done = 1'b1;
      @(posedge clk_400); #1; m_done = 1'b0; m_busy = 1'b0;
   endtask

   task automatic master_read(input logic [31:0] bytes, input int n, input bit simul);
      @(posedge clk_400); #1; m_busy = 1'b1;
      @(posedge clk_400); #1;
      for (int i = 0; i < n; i++) begin
         m_rdata = bytes[8*i +: 8]; m_rdata_valid = 1'b1;
         exp_rd.push_back('{at: cyc + 1, data: bytes[8*i +: 8]});
         if (simul && i == n - 1) m_done = 1'b1;
         @(posedge clk_400); #1; m_rdata_valid = 1'b0; m_done = 1'b0;
         @(posedge clk_400); #1;
      end
      if (!simul) begin
         m_done = 1'b1;
         @(posedge clk_400); #1; m_done = 1'b0;
      end
      m_busy = 1'b0;
   endtask

   initial begin
      int acc, s, r, st0;
      repeat (3) @(posedge clk_400);
      @(negedge clk_400);
      chk("reset_outputs", {cmd_ready, wr_ready, rd_valid, rd_data, rsp_valid, rsp_status,
                            m_start, m_rw, m_addr, m_wdata, m_more}, 32'h0);
      @(posedge clk_400); #1; rst_n = 1'b1;

      // Write 0x3C, A5 5A, plus one surplus byte-taken
      exp_w.push_back(8'hA5); exp_w.push_back(8'h5A);
      exp_rsp.push_back(ST_OK);
      st0 = n_start;
      send_cmd(1'b0, 7'h3C, 3'd2, acc);
      load(32'h00005AA5, 2);
      wait_start(s);
      chk("m_addr_wr", m_addr, 7'h3C);
      chk("m_rw_wr", m_rw, 1'b0);
      master_write(2, 1'b0, 1'b1, 8'h5A);
      wait_rsp(r);
      chk("write_start_count", n_start - st0, 1);

      // Read 0x48, three bytes with gaps
      rd_left = 3; exp_rsp.push_back(ST_OK);
      send_cmd(1'b1, 7'h48, 3'd3, acc);
      wait_start(s);
      chk("read_start_latency", s - acc, 1);
      chk("m_addr_rd", {m_rw, m_addr}, {1'b1, 7'h48});
      master_read(32'h00332211, 3, 1'b0);
      wait_rsp(r);

      // Short read: 2 of 3 bytes, done coincides with the last strobe
      rd_left = 3; exp_rsp.push_back(ST_OK);
      send_cmd(1'b1, 7'h50, 3'd3, acc);
      wait_start(s);
      master_read(32'h00005544, 2, 1'b1);
      wait_rsp(r);
      rd_left = 0;

      // NACK on address byte
      exp_rsp.push_back(ST_NACK);
      st0 = n_start;
      send_cmd(1'b0, 7'h2A, 3'd1, acc);
      load(32'h00000099, 1);
      wait_start(s);
      master_write(1, 1'b1, 1'b0, 8'h00);
      wait_rsp(r);
      repeat (5) @(posedge clk_400);
      chk("nack_no_restart", n_start - st0, 1);

      // Master never goes busy
      exp_rsp.push_back(ST_TIMEOUT);
      send_cmd(1'b1, 7'h33, 3'd1, acc);
      wait_start(s);
      wait_rsp(r);
      chk("timeout_latency", r - s, 16);
      @(negedge clk_400);
      chk("ready_after_timeout", cmd_ready, 1'b1);

      // Illegal lengths
      st0 = n_start;
      exp_rsp.push_back(ST_BADLEN);
      send_cmd(1'b0, 7'h11, 3'd0, acc);
      wait_rsp(r);
      chk("badlen0_latency", r - acc, 1);
      exp_rsp.push_back(ST_BADLEN);
      send_cmd(1'b1, 7'h11, 3'd5, acc);
      wait_rsp(r);
      chk("badlen5_latency", r - acc, 1);
      repeat (3) @(posedge clk_400);
      chk("badlen_no_start", n_start - st0, 0);

      // Reset during RUN of a 4-byte read
      rd_left = 4;
      send_cmd(1'b1, 7'h61, 3'd4, acc);
      wait_start(s);
      @(posedge clk_400); #1; m_busy = 1'b1;
      @(posedge clk_400); #1; m_rdata = 8'h77; m_rdata_valid = 1'b1;
      exp_rd.push_back('{at: cyc + 1, data: 8'h77});
      @(posedge clk_400); #1; m_rdata_valid = 1'b0;
      @(posedge clk_400); #1; rst_n = 1'b0; m_busy = 1'b0; rd_left = 0;
      @(posedge clk_400); #1; rst_n = 1'b1;
      @(negedge clk_400);
      chk("outputs_after_reset", {cmd_ready, wr_ready, rd_valid, rd_data, rsp_valid, rsp_status,
                                  m_start, m_rw, m_addr, m_wdata, m_more}, 32'h0);
      exp_w.push_back(8'hC3); exp_rsp.push_back(ST_OK);
      send_cmd(1'b0, 7'h10, 3'd1, acc);
      load(32'h000000C3, 1);
      wait_start(s);
      master_write(1, 1'b0, 1'b0, 8'h00);
      wait_rsp(r);

      repeat (3) @(negedge clk_400);
      chk("rsp_queue_drained", exp_rsp.size(), 0);
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("wr_queue_drained", exp_w.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
